// File: rtl/rv_trace_fifo.sv
// Retirement trace FIFO: merges rf writes and dm stores into one ordered stream.
// Show-ahead head, up to two pushes per cycle, saturating drop counter.
module rv_trace_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en_i,
    input  logic                     rf_we_i,
    input  logic [4:0]               rf_addr_i,
    input  logic [31:0]              rf_data_i,
    input  logic                     dm_we_i,
    input  logic [31:0]              dm_addr_i,
    input  logic [31:0]              dm_data_i,
    input  logic [3:0]               dm_be_i,
    output logic                     trc_valid_o,
    input  logic                     trc_ready_i,
    output logic                     trc_kind_o,
    output logic [31:0]              trc_addr_o,
    output logic [31:0]              trc_data_o,
    output logic [3:0]               trc_be_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic [15:0]              drop_cnt_o,
    output logic                     overflow_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int EW = 69;

    logic [EW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [LW-1:0] free;
    logic [15:0]   drop_q, drop_d;
    logic          ovf_q, ovf_d;
    logic          rf_ev, dm_ev, pop;
    logic [1:0]    n_ev, n_push, n_drop;
    logic [EW-1:0] rf_ent, dm_ent, ent0, head;
    logic [16:0]   drop_sum;

    always_comb begin
        rf_ev  = en_i & rf_we_i & (rf_addr_i != 5'd0);
        dm_ev  = en_i & dm_we_i & (dm_be_i != 4'd0);
        rf_ent = {1'b0, 27'b0, rf_addr_i, rf_data_i, 4'hF};
        dm_ent = {1'b1, dm_addr_i, dm_data_i, dm_be_i};
        ent0   = rf_ev ? rf_ent : dm_ent;
        n_ev   = {1'b0, rf_ev} + {1'b0, dm_ev};
        // space is judged on start-of-cycle occupancy; a pop frees nothing yet
        free   = LW'(DEPTH) - level_q;
        n_push = 2'd0;
        if (free >= LW'(2)) begin
            n_push = n_ev;
        end else if (free == LW'(1) && n_ev != 2'd0) begin
            n_push = 2'd1;
        end
        n_drop   = n_ev - n_push;
        pop      = (level_q != '0) & trc_ready_i;
        wr_ptr_d = wr_ptr_q + AW'(n_push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        level_d  = level_q + LW'(n_push) - LW'(pop);
        drop_sum = {1'b0, drop_q} + 17'(n_drop);
        drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        ovf_d    = ovf_q | (n_drop != 2'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            drop_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            drop_q   <= drop_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && n_push != 2'd0) begin
            mem_q[wr_ptr_q] <= ent0;
        end
        if (!rst && n_push == 2'd2) begin
            mem_q[wr_ptr_q + AW'(1)] <= dm_ent;
        end
    end

    assign head        = mem_q[rd_ptr_q];
    assign trc_kind_o  = head[68];
    assign trc_addr_o  = head[67:36];
    assign trc_data_o  = head[35:4];
    assign trc_be_o    = head[3:0];
    assign trc_valid_o = (level_q != '0);
    assign level_o     = level_q;
    assign drop_cnt_o  = drop_q;
    assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_rv_trace_fifo.sv
// Bench for rv_trace_fifo: queue-based reference model, per-cycle compare,
// directed corner cases plus randomized traffic.
module tb_rv_trace_fifo;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        en, rf_we, dm_we, rdy;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data, dm_addr, dm_data;
    logic [3:0]  dm_be;
    logic        trc_valid_o, trc_kind_o, overflow_o;
    logic [31:0] trc_addr_o, trc_data_o;
    logic [3:0]  trc_be_o;
    logic [4:0]  level_o;
    logic [15:0] drop_cnt_o;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_on  = 1'b0;

    logic [68:0] mq[$];
    int          mdrop;
    bit          movf;

    always #5 clk = ~clk;

    rv_trace_fifo #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .en_i(en),
        .rf_we_i(rf_we), .rf_addr_i(rf_addr), .rf_data_i(rf_data),
        .dm_we_i(dm_we), .dm_addr_i(dm_addr), .dm_data_i(dm_data),
        .dm_be_i(dm_be), .trc_valid_o(trc_valid_o), .trc_ready_i(rdy),
        .trc_kind_o(trc_kind_o), .trc_addr_o(trc_addr_o),
        .trc_data_o(trc_data_o), .trc_be_o(trc_be_o),
        .level_o(level_o), .drop_cnt_o(drop_cnt_o), .overflow_o(overflow_o)
    );

    function automatic void chk(string n, logic [71:0] a, logic [71:0] e);
        n_tests++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endfunction

    // Reference: a queue of entries; events become entries while room remains.
    task automatic model_step();
        logic [68:0] ev[$];
        int free;
        int nd;
        bit pop;
        if (rst) begin
            mq.delete();
            mdrop = 0;
            movf  = 1'b0;
            return;
        end
        free = DEPTH - mq.size();
        pop  = (mq.size() != 0) && rdy;
        if (en && rf_we && rf_addr != 5'd0)
            ev.push_back({1'b0, 27'b0, rf_addr, rf_data, 4'hF});
        if (en && dm_we && dm_be != 4'd0)
            ev.push_back({1'b1, dm_addr, dm_data, dm_be});
        nd = 0;
        foreach (ev[i]) begin
            if (i < free) mq.push_back(ev[i]);
            else nd++;
        end
        if (pop) void'(mq.pop_front());
        mdrop = (mdrop + nd > 65535) ? 65535 : mdrop + nd;
        if (nd != 0) movf = 1'b1;
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("valid", trc_valid_o, mq.size() != 0);
            chk("level", level_o, mq.size());
            chk("drop_cnt", drop_cnt_o, mdrop);
            chk("overflow", overflow_o, movf);
            if (mq.size() != 0)
                chk("head", {trc_kind_o, trc_addr_o, trc_data_o, trc_be_o}, mq[0]);
        end
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        chk_on = 1'b1;
        #1;
    endtask

    task automatic clr();
        en = 1'b1; rf_we = 1'b0; dm_we = 1'b0;
        rf_addr = '0; rf_data = '0; dm_addr = '0; dm_data = '0; dm_be = '0;
    endtask

    task automatic set_rf(logic [4:0] a, logic [31:0] d);
        rf_we = 1'b1; rf_addr = a; rf_data = d;
    endtask

    task automatic set_dm(logic [31:0] a, logic [31:0] d, logic [3:0] b);
        dm_we = 1'b1; dm_addr = a; dm_data = d; dm_be = b;
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b0; clr();
        mdrop = 0; movf = 1'b0;
        tick(); tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", trc_valid_o, 1'b0);
        chk("rst_level", level_o, 5'd0);
        chk("rst_drop", drop_cnt_o, 16'd0);
        chk("rst_ovf", overflow_o, 1'b0);

        set_rf(5'd5, 32'hDEADBEEF);
        tick(); clr();
        @(negedge clk);
        chk("x5_valid", trc_valid_o, 1'b1);
        chk("x5_kind", trc_kind_o, 1'b0);
        chk("x5_addr", trc_addr_o, 32'd5);
        chk("x5_data", trc_data_o, 32'hDEADBEEF);
        chk("x5_be", trc_be_o, 4'hF);
        rdy = 1'b1; tick(); rdy = 1'b0;

        set_rf(5'd0, 32'h1); set_dm(32'h40, 32'h7, 4'h0);
        tick(); clr();
        @(negedge clk);
        chk("x0_level", level_o, 5'd0);
        chk("x0_drop", drop_cnt_o, 16'd0);

        set_rf(5'd3, 32'h11); set_dm(32'h100, 32'h22, 4'hF);
        tick(); clr();
        @(negedge clk);
        chk("dual_level", level_o, 5'd2);
        chk("dual_first", {trc_kind_o, trc_addr_o, trc_data_o}, {1'b0, 32'd3, 32'h11});
        rdy = 1'b1; tick();
        @(negedge clk);
        chk("dual_second", {trc_kind_o, trc_addr_o, trc_data_o}, {1'b1, 32'h100, 32'h22});
        tick(); rdy = 1'b0;

        for (int i = 0; i < DEPTH - 1; i++) begin
            set_rf(5'(i + 1), $urandom);
            tick();
        end
        set_rf(5'd7, 32'hA); set_dm(32'h200, 32'hB, 4'h3);
        tick(); clr();
        @(negedge clk);
        chk("one_free_level", level_o, 5'd16);
        chk("one_free_drop", drop_cnt_o, 16'd1);
        chk("one_free_ovf", overflow_o, 1'b1);

        rdy = 1'b1;
        set_rf(5'd8, 32'hC); set_dm(32'h204, 32'hD, 4'h1);
        tick(); clr(); rdy = 1'b0;
        @(negedge clk);
        chk("full_pop_level", level_o, 5'd15);
        chk("full_pop_drop", drop_cnt_o, 16'd3);

        set_rf(5'd9, 32'hE); tick();
        set_rf(5'd9, 32'hF); tick();
        set_dm(32'h300, 32'h1, 4'hF);
        for (int i = 0; i < 32765; i++) tick();
        @(negedge clk);
        chk("sat_fffe", drop_cnt_o, 16'hFFFE);
        tick();
        @(negedge clk);
        chk("sat_ffff", drop_cnt_o, 16'hFFFF);
        tick();
        @(negedge clk);
        chk("sat_hold", drop_cnt_o, 16'hFFFF);
        rst = 1'b1; tick(); rst = 1'b0; clr();
        @(negedge clk);
        chk("rst2_all", {trc_valid_o, level_o, drop_cnt_o, overflow_o}, 23'd0);

        for (int i = 0; i < 3000; i++) begin
            rst     = ($urandom_range(0, 299) == 0);
            en      = ($urandom_range(0, 7) != 0);
            rf_we   = $urandom_range(0, 1);
            rf_addr = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
            rf_data = $urandom;
            dm_we   = $urandom_range(0, 1);
            dm_addr = $urandom;
            dm_data = $urandom;
            dm_be   = 4'($urandom);
            rdy     = ($urandom_range(0, 2) == 0);
            tick();
        end
        rst = 1'b0; clr();
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
